// File: rtl/daq_multi_buffer.sv
// daq_multi_buffer
//  Single-clock DAQ capture buffer. Frames of NCH samples are captured on a
//  (pipelined) write strobe into an inferred block RAM. They are then streamed
//  to the UART as CHUNK_W-bit chunks using a ready/loaded handshake. The order
//  is frame ascending, then selected channel ascending, then slice LSB-first.
// Ports
//  clk, reset        system clock, synchronous active-high reset
//  wr_en, wr_data    capture strobe and frame (channel c at [c*DATA_W +: DATA_W])
//  clear             empty the buffer and clear overflow (acted on in IDLE only)
//  ch_mask           channels to transmit, latched when leaving IDLE
//  tx_en             level: run (1) or abort/finish (0) a transmission
//  tx_data_loaded    UART acknowledge, asynchronous, synchronised here
//  tx_data           current chunk (registered)
//  tx_data_ready     tx_data valid, held until the acknowledge is seen
//  tx_complete       every selected chunk has been sent, held until tx_en drops
//  tx_busy           transmitter not idle
//  overflow          sticky: at least one captured frame was dropped
//  frame_count       number of stored frames, 0..2**ADDR_W
module daq_multi_buffer #(
  parameter int DATA_W  = 14,
  parameter int CHUNK_W = 7,
  parameter int NCH     = 2,
  parameter int ADDR_W  = 10,
  parameter int WR_PIPE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [NCH*DATA_W-1:0] wr_data,
  input  logic                  clear,
  input  logic [NCH-1:0]        ch_mask,
  input  logic                  tx_en,
  input  logic                  tx_data_loaded,
  output logic [CHUNK_W-1:0]    tx_data,
  output logic                  tx_data_ready,
  output logic                  tx_complete,
  output logic                  tx_busy,
  output logic                  overflow,
  output logic [ADDR_W:0]       frame_count
);

  localparam int NSLICE  = DATA_W / CHUNK_W;
  localparam int NCHUNK  = NCH * NSLICE;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int FRAME_W = NCH * DATA_W;
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SL_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int CK_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_COUNT  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_PRESENT, ST_RELEASE, ST_DONE} state_t;

  state_t               state_reg;
  logic                 fetch_ph_reg;
  logic [NCH-1:0]       mask_reg;
  logic [ADDR_W:0]      frame_idx_reg;
  logic [CH_W-1:0]      ch_idx_reg;
  logic [SL_W-1:0]      slice_idx_reg;
  logic                 last_reg;
  logic [CHUNK_W-1:0]   tx_data_reg;
  logic                 ready_reg;
  logic                 complete_reg;
  logic                 load_meta_reg;
  logic                 load_sync_reg;
  logic [ADDR_W:0]      frame_count_reg;
  logic                 overflow_reg;

  logic                 pipe_en_reg   [WR_PIPE];
  logic [FRAME_W-1:0]   pipe_data_reg [WR_PIPE];
  logic [FRAME_W-1:0]   mem [DEPTH];
  logic [FRAME_W-1:0]   rd_data_reg;
  logic [CHUNK_W-1:0]   chunk_arr [NCHUNK];
  logic [CK_W-1:0]      chunk_sel;
  logic                 mem_we;
  logic                 clear_now;
  logic [CH_W-1:0]      next_ch;
  logic                 more_ch;
  logic                 is_last;

  // Lowest set channel strictly above 'above' (-1 gives the first selected channel).
  function automatic logic [CH_W-1:0] lowest_ch(input logic [NCH-1:0] m, input int above);
    logic [CH_W-1:0] r;
    r = '0;
    for (int c = NCH - 1; c >= 0; c--)
      if (m[c] && c > above) r = CH_W'(c);
    return r;
  endfunction

  function automatic logic any_ch(input logic [NCH-1:0] m, input int above);
    logic r;
    r = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (m[c] && c > above) r = 1'b1;
    return r;
  endfunction

  // Write strobe/data delay line in front of the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WR_PIPE; i++) begin
        pipe_en_reg[i]   <= 1'b0;
        pipe_data_reg[i] <= '0;
      end
    end else begin
      pipe_en_reg[0]   <= wr_en;
      pipe_data_reg[0] <= wr_data;
      for (int i = 1; i < WR_PIPE; i++) begin
        pipe_en_reg[i]   <= pipe_en_reg[i-1];
        pipe_data_reg[i] <= pipe_data_reg[i-1];
      end
    end
  end

  // A landing write is only accepted while idle with room left; a clear in the
  // same cycle wins and the write is discarded along with the old contents.
  always_comb begin
    clear_now = (state_reg == ST_IDLE) && clear;
    mem_we    = pipe_en_reg[WR_PIPE-1] && (state_reg == ST_IDLE) && !clear &&
                (frame_count_reg != FULL_COUNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_reg <= '0;
      overflow_reg    <= 1'b0;
    end else if (clear_now) begin
      frame_count_reg <= '0;
      overflow_reg    <= 1'b0;
    end else if (mem_we) begin
      frame_count_reg <= frame_count_reg + ONE_COUNT;
    end else if (pipe_en_reg[WR_PIPE-1]) begin
      overflow_reg    <= 1'b1;
    end
  end

  // Frame store: one write port, registered read addressed by the read frame.
  always_ff @(posedge clk) begin
    if (mem_we) mem[frame_count_reg[ADDR_W-1:0]] <= pipe_data_reg[WR_PIPE-1];
    rd_data_reg <= mem[frame_idx_reg[ADDR_W-1:0]];
  end

  // Channel c slice s sits at chunk index c*NSLICE+s of the frame word.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign chunk_arr[gi] = rd_data_reg[gi*CHUNK_W +: CHUNK_W];
    end
  endgenerate

  always_comb begin
    chunk_sel = CK_W'(int'(ch_idx_reg) * NSLICE + int'(slice_idx_reg));
    next_ch   = lowest_ch(mask_reg, int'(ch_idx_reg));
    more_ch   = any_ch(mask_reg, int'(ch_idx_reg));
    is_last   = (slice_idx_reg == SL_W'(NSLICE - 1)) && !more_ch &&
                ((frame_idx_reg + ONE_COUNT) == frame_count_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      fetch_ph_reg  <= 1'b0;
      mask_reg      <= '0;
      frame_idx_reg <= '0;
      ch_idx_reg    <= '0;
      slice_idx_reg <= '0;
      last_reg      <= 1'b0;
      tx_data_reg   <= '0;
      ready_reg     <= 1'b0;
      complete_reg  <= 1'b0;
      load_meta_reg <= 1'b0;
      load_sync_reg <= 1'b0;
    end else begin
      load_meta_reg <= tx_data_loaded;
      load_sync_reg <= load_meta_reg;
      // Dropping tx_en mid-stream abandons it; the next start replays from frame 0.
      if (!tx_en && (state_reg == ST_FETCH || state_reg == ST_PRESENT ||
                     state_reg == ST_RELEASE)) begin
        state_reg     <= ST_IDLE;
        ready_reg     <= 1'b0;
        fetch_ph_reg  <= 1'b0;
        frame_idx_reg <= '0;
        ch_idx_reg    <= '0;
        slice_idx_reg <= '0;
        last_reg      <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            ready_reg     <= 1'b0;
            complete_reg  <= 1'b0;
            fetch_ph_reg  <= 1'b0;
            frame_idx_reg <= '0;
            slice_idx_reg <= '0;
            last_reg      <= 1'b0;
            if (tx_en) begin
              mask_reg   <= ch_mask;
              ch_idx_reg <= lowest_ch(ch_mask, -1);
              if (frame_count_reg == '0 || ch_mask == '0) begin
                state_reg    <= ST_DONE;
                complete_reg <= 1'b1;
              end else begin
                state_reg    <= ST_FETCH;
              end
            end
          end
          // Phase 0 presents the address, phase 1 takes the RAM output.
          ST_FETCH: begin
            if (fetch_ph_reg) begin
              tx_data_reg  <= chunk_arr[chunk_sel];
              fetch_ph_reg <= 1'b0;
              state_reg    <= ST_PRESENT;
            end else begin
              fetch_ph_reg <= 1'b1;
            end
          end
          // Ready is raised first, so an acknowledge already high on entry
          // still yields one ready cycle before it is consumed.
          ST_PRESENT: begin
            if (!ready_reg) begin
              ready_reg <= 1'b1;
            end else if (load_sync_reg) begin
              ready_reg <= 1'b0;
              last_reg  <= is_last;
              state_reg <= ST_RELEASE;
              if (slice_idx_reg != SL_W'(NSLICE - 1)) begin
                slice_idx_reg <= slice_idx_reg + 1'b1;
              end else begin
                slice_idx_reg <= '0;
                if (more_ch) begin
                  ch_idx_reg <= next_ch;
                end else begin
                  ch_idx_reg    <= lowest_ch(mask_reg, -1);
                  frame_idx_reg <= frame_idx_reg + ONE_COUNT;
                end
              end
            end
          end
          ST_RELEASE: begin
            if (!load_sync_reg) begin
              if (last_reg) begin
                state_reg    <= ST_DONE;
                complete_reg <= 1'b1;
              end else begin
                state_reg    <= ST_FETCH;
              end
            end
          end
          ST_DONE: begin
            if (!tx_en) begin
              state_reg     <= ST_IDLE;
              complete_reg  <= 1'b0;
              frame_idx_reg <= '0;
              ch_idx_reg    <= '0;
              slice_idx_reg <= '0;
              last_reg      <= 1'b0;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_data       = tx_data_reg;
  assign tx_data_ready = ready_reg;
  assign tx_complete   = complete_reg;
  assign tx_busy       = (state_reg != ST_IDLE);
  assign overflow      = overflow_reg;
  assign frame_count   = frame_count_reg;

endmodule

// File: tb/tb_daq_multi_buffer.sv
// Bench for daq_multi_buffer: random and directed stimulus, a frame-list model
// of the buffer, a UART responder and a per-cycle compare process.
module tb_daq_multi_buffer;
  localparam int DATA_W = 14, CHUNK_W = 7, NCH = 2, ADDR_W = 10, WR_PIPE = 4;
  localparam int NSLICE = DATA_W / CHUNK_W;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int FW     = NCH * DATA_W;

  logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, clear = 1'b0, tx_en = 1'b0, tx_data_loaded = 1'b0;
  logic [FW-1:0]      wr_data = '0;
  logic [NCH-1:0]     ch_mask = '0;
  logic [CHUNK_W-1:0] tx_data;
  logic tx_data_ready, tx_complete, tx_busy, overflow;
  logic [ADDR_W:0]    frame_count;

  daq_multi_buffer #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .NCH(NCH), .ADDR_W(ADDR_W), .WR_PIPE(WR_PIPE)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clear(clear), .ch_mask(ch_mask),
    .tx_en(tx_en), .tx_data_loaded(tx_data_loaded), .tx_data(tx_data), .tx_data_ready(tx_data_ready),
    .tx_complete(tx_complete), .tx_busy(tx_busy), .overflow(overflow), .frame_count(frame_count));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [FW-1:0]      model_frames [DEPTH];
  int                 model_count = 0;
  bit                 model_ovf = 1'b0;
  bit                 chk_en = 1'b0;
  logic [CHUNK_W-1:0] exp_q[$], rx_q[$], lit_q[$];
  logic [CHUNK_W-1:0] prev_data = '0;
  logic               prev_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: buffer occupancy and handshake invariants every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("frame_count", 32'(frame_count), 32'(model_count));
      check("overflow", 32'(overflow), 32'(model_ovf));
      if (tx_data_ready) check("busy_while_ready", 32'(tx_busy), 32'd1);
      if (tx_data_ready && prev_ready) check("data_stable", 32'(tx_data), 32'(prev_data));
      check("ready_and_complete", 32'(tx_data_ready & tx_complete), 32'd0);
    end
    prev_ready = tx_data_ready;
    prev_data  = tx_data;
  end

  // Model: a frame is stored when it lands (WR_PIPE clocks after its strobe)
  // unless the transmitter is busy or the buffer is full.
  task automatic write_frame(input logic [FW-1:0] d, input bit during_tx);
    @(posedge clk); #1 wr_en = 1'b1; wr_data = d;
    @(posedge clk); #1 wr_en = 1'b0;
    repeat (WR_PIPE) @(posedge clk);
    #1;
    if (during_tx || model_count == DEPTH) model_ovf = 1'b1;
    else begin
      model_frames[model_count] = d;
      model_count++;
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    model_count = 0;
    model_ovf   = 1'b0;
  endtask

  function automatic void build_exp(input logic [NCH-1:0] m);
    logic [FW-1:0] fr;
    exp_q.delete();
    for (int f = 0; f < model_count; f++) begin
      fr = model_frames[f];
      for (int c = 0; c < NCH; c++)
        if (m[c])
          for (int s = 0; s < NSLICE; s++)
            exp_q.push_back(fr[c*DATA_W + s*CHUNK_W +: CHUNK_W]);
    end
  endfunction

  // UART responder. stop_after >= 0 drops tx_en once that many chunks are done.
  task automatic run_tx(input logic [NCH-1:0] m, input int stop_after);
    int ph, dly, got, n;
    bit fin;
    build_exp(m);
    n = exp_q.size();
    rx_q.delete();
    @(posedge clk); #1 ch_mask = m; tx_en = 1'b1;
    ph = 0; got = 0; fin = 1'b0; dly = 0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      case (ph)
        0: if (tx_data_ready) begin
             rx_q.push_back(tx_data);
             if (got < n) check("chunk", 32'(tx_data), 32'(exp_q[got]));
             else check("extra_chunk_ready", 32'(tx_data_ready), 32'd0);
             got++;
             dly = $urandom_range(0, 3);
             ph = 1;
           end else if (got == stop_after) begin
             fin = 1'b1;
           end else if (tx_complete) begin
             check("chunks_at_complete", 32'(got), 32'(n));
             fin = 1'b1;
           end
        1: if (dly == 0) begin tx_data_loaded = 1'b1; ph = 2; end else dly--;
        2: if (!tx_data_ready) begin dly = $urandom_range(0, 3); ph = 3; end
        default: if (dly == 0) begin tx_data_loaded = 1'b0; ph = 0; end else dly--;
      endcase
    end
    check("tx_finished_in_budget", 32'(fin), 32'd1);
    tx_data_loaded = 1'b0;
    @(posedge clk); #1 tx_en = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle_after_tx_en_low", 32'(tx_busy), 32'd0);
    check("complete_after_tx_en_low", 32'(tx_complete), 32'd0);
    check("ready_after_tx_en_low", 32'(tx_data_ready), 32'd0);
    repeat (4) @(posedge clk);
  endtask

  task automatic compare_rx_lit(input string name);
    check({name, "_len"}, 32'(rx_q.size()), 32'(lit_q.size()));
    for (int i = 0; i < lit_q.size() && i < rx_q.size(); i++)
      check(name, 32'(rx_q[i]), 32'(lit_q[i]));
  endtask

  // Start with nothing to send: complete one clock later, never ready.
  task automatic quick_done(input logic [NCH-1:0] m, input string name);
    @(posedge clk); #1 ch_mask = m; tx_en = 1'b1;
    @(posedge clk); @(negedge clk);
    check({name, "_complete"}, 32'(tx_complete), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check({name, "_no_ready"}, 32'(tx_data_ready), 32'd0);
    end
    @(posedge clk); #1 tx_en = 1'b0;
    @(posedge clk); @(negedge clk);
    check({name, "_complete_clr"}, 32'(tx_complete), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, n, tot, stop;
    logic [NCH-1:0] m;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_ready", 32'(tx_data_ready), 32'd0);
    check("rst_complete", 32'(tx_complete), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    chk_en = 1'b1;

    // Two known frames, all channels.
    write_frame({14'h0123, 14'h1ABC}, 1'b0);
    write_frame({14'h0000, 14'h3FFF}, 1'b0);
    check("two_frames_count", 32'(frame_count), 32'd2);
    run_tx(2'b11, -1);
    lit_q = '{7'h3C, 7'h35, 7'h23, 7'h02, 7'h7F, 7'h7F, 7'h00, 7'h00};
    compare_rx_lit("mask11_stream");

    // Channel 1 only, then nothing selected.
    run_tx(2'b10, -1);
    lit_q = '{7'h23, 7'h02, 7'h00, 7'h00};
    compare_rx_lit("mask10_stream");
    quick_done(2'b00, "mask00");

    // Abort after the third chunk, then a full restart from chunk 0.
    run_tx(2'b11, 3);
    check("abort_rx_len", 32'(rx_q.size()), 32'd3);
    run_tx(2'b11, -1);
    lit_q = '{7'h3C, 7'h35, 7'h23, 7'h02, 7'h7F, 7'h7F, 7'h00, 7'h00};
    compare_rx_lit("restart_stream");

    // A write landing mid-transmission is dropped and flags overflow.
    fork
      run_tx(2'b11, -1);
      begin
        for (int i = 0; i < 200 && !tx_data_ready; i++) @(negedge clk);
        write_frame(FW'($urandom()), 1'b1);
      end
    join
    check("tx_write_overflow", 32'(overflow), 32'd1);
    check("tx_write_rx_len", 32'(rx_q.size()), 32'd8);

    // Empty buffer.
    do_clear();
    @(negedge clk);
    check("clear_count", 32'(frame_count), 32'd0);
    check("clear_overflow", 32'(overflow), 32'd0);
    quick_done(2'b11, "empty");

    // Fill past DEPTH, clear, next write lands at address 0.
    for (int i = 0; i < DEPTH + 3; i++) write_frame(FW'({$urandom(), $urandom()}), 1'b0);
    @(negedge clk);
    check("full_count", 32'(frame_count), 32'(DEPTH));
    check("full_overflow", 32'(overflow), 32'd1);
    do_clear();
    write_frame({14'h2AAA, 14'h1555}, 1'b0);
    run_tx(2'b11, -1);
    lit_q = '{7'h55, 7'h2A, 7'h2A, 7'h55};
    compare_rx_lit("after_clear_stream");

    // Random frame sets, masks and aborts.
    for (int it = 0; it < 8; it++) begin
      do_clear();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) write_frame(FW'({$urandom(), $urandom()}), 1'b0);
      m = NCH'($urandom_range(0, 3));
      tot = n * $countones(m) * NSLICE;
      if (tot >= 2 && ($urandom_range(0, 2) == 0)) begin
        stop = $urandom_range(1, tot - 1);
        run_tx(m, stop);
        check("rand_abort_len", 32'(rx_q.size()), 32'(stop));
      end
      run_tx(m, -1);
      check("rand_rx_len", 32'(rx_q.size()), 32'(tot));
    end

    // Ready latency, then reset while a chunk is presented.
    write_frame({14'h0ABC, 14'h1DEF}, 1'b0);
    @(posedge clk); #1 ch_mask = 2'b11; tx_en = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_data_ready) break;
      lat++;
    end
    // Four low samples: tx_en sampled at the first edge, ready rises 3 edges later.
    check("ready_latency", 32'(lat), 32'd4);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; tx_en = 1'b0;
    model_count = 0;
    model_ovf   = 1'b0;
    @(negedge clk);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_ready", 32'(tx_data_ready), 32'd0);
    check("mid_rst_complete", 32'(tx_complete), 32'd0);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    check("mid_rst_count", 32'(frame_count), 32'd0);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
